// File: rtl/boe_result_rx_if.sv
// Input-side bundle for the BOE result receiver.
// The upstream producer drives the frame start and the result words; the receiver only listens.
interface boe_result_rx_if #(
  parameter int DW = 8
);
  logic          start;
  logic [2:0]    data_num;
  logic          res_valid;
  logic [DW+2:0] result;

  modport master (
    output start,
    output data_num,
    output res_valid,
    output result
  );

  modport slave (
    input start,
    input data_num,
    input res_valid,
    input result
  );
endinterface

// File: rtl/boe_result_rx.sv
// Receive-side parser and checker for one BOE result frame.
// A frame is a sum word, then a max word, then N sorted element words.
module boe_result_rx #(
  parameter int MAX_N = 6,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  boe_result_rx_if.slave        bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DW+2:0]         sum_out,
  output logic [DW-1:0]         max_out,
  output logic [MAX_N*DW-1:0]   elems_out,
  output logic                  err_sum,
  output logic                  err_max,
  output logic                  err_order,
  output logic                  err_range,
  output logic                  err_frame
);

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    MAX,
    ELEM,
    DONE
  } state_t;

  localparam logic [2:0] MAX_N3 = 3'(MAX_N);

  state_t        state;
  logic [2:0]    n;
  logic [2:0]    k;
  logic [DW+2:0] acc;
  logic          zero_seen;
  logic [DW-1:0] prev;

  logic [DW-1:0] elem_byte;
  logic [DW+2:0] acc_next;
  logic          zero_next;
  logic [DW-1:0] elem0_next;
  logic          last_elem;
  logic          num_ok;

  // The consistency checks must see the word accepted on the same edge that enters DONE.
  always_comb begin
    elem_byte  = bus.result[DW-1:0];
    acc_next   = acc + {3'b000, elem_byte};
    zero_next  = zero_seen | (elem_byte == '0);
    elem0_next = (k == 3'd0) ? elem_byte : elems_out[DW-1:0];
    last_elem  = (k == n - 3'd1);
    num_ok     = (bus.data_num != 3'd0) && (bus.data_num <= MAX_N3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      k          <= '0;
      acc        <= '0;
      zero_seen  <= 1'b0;
      prev       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sum_out    <= '0;
      max_out    <= '0;
      elems_out  <= '0;
      err_sum    <= 1'b0;
      err_max    <= 1'b0;
      err_order  <= 1'b0;
      err_range  <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy      <= 1'b1;
            err_sum   <= 1'b0;
            err_max   <= 1'b0;
            err_order <= 1'b0;
            err_range <= 1'b0;
            if (num_ok) begin
              n         <= bus.data_num;
              k         <= '0;
              acc       <= '0;
              zero_seen <= 1'b0;
              prev      <= '0;
              elems_out <= '0;
              err_frame <= 1'b0;
              state     <= SUM;
            end else begin
              err_frame  <= 1'b1;
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end

        SUM, MAX, ELEM: begin
          if (bus.start) begin
            // Abort keeps the partial capture but the sum/max checks are meaningless.
            err_frame  <= 1'b1;
            err_sum    <= 1'b0;
            err_max    <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else if (bus.res_valid) begin
            if (state == SUM) begin
              sum_out <= bus.result;
              state   <= MAX;
            end else if (state == MAX) begin
              max_out <= elem_byte;
              k       <= '0;
              state   <= ELEM;
            end else begin
              elems_out[k*DW +: DW] <= elem_byte;
              acc       <= acc_next;
              zero_seen <= zero_next;
              prev      <= elem_byte;
              if (bus.result[DW+2:DW] != 3'b000)
                err_range <= 1'b1;
              if ((k != 3'd0) && (elem_byte > prev))
                err_order <= 1'b1;
              if (last_elem) begin
                err_sum    <= (acc_next != sum_out);
                err_max    <= zero_next ? (max_out != '0) : (max_out != elem0_next);
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                k <= k + 3'd1;
              end
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
